// File: rtl/time_counter_hms_if.sv
// Control, preset and display bundle for the HH:MM:SS BCD time counter.
// The master side drives controls and presets; the counter drives digits and status flags.
interface time_counter_hms_if #(
    parameter int SIZE = 4
);
    logic            pulse;
    logic            start;
    logic            stop;
    logic            restart;
    logic            load;
    logic            dir;
    logic [2*SIZE-1:0] preset_h;
    logic [2*SIZE-1:0] preset_m;
    logic [2*SIZE-1:0] preset_s;
    logic [SIZE-1:0] hours_tens;
    logic [SIZE-1:0] hours_units;
    logic [SIZE-1:0] minutes_tens;
    logic [SIZE-1:0] minutes_units;
    logic [SIZE-1:0] seconds_tens;
    logic [SIZE-1:0] seconds_units;
    logic            running;
    logic            expired;
    logic            expire_pulse;
    logic            rollover_pulse;

    modport master (
        output pulse, start, stop, restart, load, dir, preset_h, preset_m, preset_s,
        input  hours_tens, hours_units, minutes_tens, minutes_units,
               seconds_tens, seconds_units, running, expired, expire_pulse, rollover_pulse
    );

    modport slave (
        input  pulse, start, stop, restart, load, dir, preset_h, preset_m, preset_s,
        output hours_tens, hours_units, minutes_tens, minutes_units,
               seconds_tens, seconds_units, running, expired, expire_pulse, rollover_pulse
    );
endinterface

// File: rtl/time_counter_hms.sv
// HH:MM:SS BCD up/down counter with preset load, start/stop and expiry/rollover flags.
// Counts one second per pulse while running; all outputs are registered.
module time_counter_hms #(
    parameter int SIZE     = 4,
    parameter int HOUR_MAX = 23,
    parameter bit WRAP_UP  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    time_counter_hms_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    localparam logic [SIZE-1:0] D0 = '0;
    localparam logic [SIZE-1:0] D1 = SIZE'(1);
    localparam logic [SIZE-1:0] D5 = SIZE'(5);
    localparam logic [SIZE-1:0] D9 = SIZE'(9);
    localparam logic [SIZE-1:0] HT = SIZE'(HOUR_MAX / 10);
    localparam logic [SIZE-1:0] HU = SIZE'(HOUR_MAX % 10);

    state_t          state_reg;
    logic            dir_reg;
    logic            expire_pulse_reg, rollover_pulse_reg, running_reg, expired_reg;
    logic [SIZE-1:0] h_t_reg, h_u_reg, m_t_reg, m_u_reg, s_t_reg, s_u_reg;

    logic [SIZE-1:0] inc_ht, inc_hu, inc_mt, inc_mu, inc_st, inc_su;
    logic [SIZE-1:0] dec_ht, dec_hu, dec_mt, dec_mu, dec_st, dec_su;
    logic [SIZE-1:0] ld_ht, ld_hu, ld_mt, ld_mu, ld_st, ld_su;
    logic [SIZE-1:0] ph_t, ph_u, ph_u_c;
    int              h_val;
    logic            all_zero, is_one, at_max;

    assign all_zero = (h_t_reg == D0) && (h_u_reg == D0) && (m_t_reg == D0) &&
                      (m_u_reg == D0) && (s_t_reg == D0) && (s_u_reg == D0);
    // 00:00:01 is the only value whose decrement lands on zero
    assign is_one   = (h_t_reg == D0) && (h_u_reg == D0) && (m_t_reg == D0) &&
                      (m_u_reg == D0) && (s_t_reg == D0) && (s_u_reg == D1);
    assign at_max   = (h_t_reg == HT) && (h_u_reg == HU) && (m_t_reg == D5) &&
                      (m_u_reg == D9) && (s_t_reg == D5) && (s_u_reg == D9);

    always_comb begin
        {inc_ht, inc_hu, inc_mt, inc_mu, inc_st, inc_su} =
            {h_t_reg, h_u_reg, m_t_reg, m_u_reg, s_t_reg, s_u_reg};
        if (s_u_reg != D9) inc_su = s_u_reg + D1;
        else begin
            inc_su = D0;
            if (s_t_reg != D5) inc_st = s_t_reg + D1;
            else begin
                inc_st = D0;
                if (m_u_reg != D9) inc_mu = m_u_reg + D1;
                else begin
                    inc_mu = D0;
                    if (m_t_reg != D5) inc_mt = m_t_reg + D1;
                    else begin
                        inc_mt = D0;
                        if (h_u_reg != D9) inc_hu = h_u_reg + D1;
                        else begin
                            inc_hu = D0;
                            inc_ht = h_t_reg + D1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        {dec_ht, dec_hu, dec_mt, dec_mu, dec_st, dec_su} =
            {h_t_reg, h_u_reg, m_t_reg, m_u_reg, s_t_reg, s_u_reg};
        if (s_u_reg != D0) dec_su = s_u_reg - D1;
        else begin
            dec_su = D9;
            if (s_t_reg != D0) dec_st = s_t_reg - D1;
            else begin
                dec_st = D5;
                if (m_u_reg != D0) dec_mu = m_u_reg - D1;
                else begin
                    dec_mu = D9;
                    if (m_t_reg != D0) dec_mt = m_t_reg - D1;
                    else begin
                        dec_mt = D5;
                        if (h_u_reg != D0) dec_hu = h_u_reg - D1;
                        else begin
                            dec_hu = D9;
                            dec_ht = h_t_reg - D1;
                        end
                    end
                end
            end
        end
    end

    // Preset clamping: per-digit limits first, then the whole hours value against HOUR_MAX
    always_comb begin
        ld_st  = (bus.preset_s[2*SIZE-1:SIZE] > D5) ? D5 : bus.preset_s[2*SIZE-1:SIZE];
        ld_su  = (bus.preset_s[SIZE-1:0]      > D9) ? D9 : bus.preset_s[SIZE-1:0];
        ld_mt  = (bus.preset_m[2*SIZE-1:SIZE] > D5) ? D5 : bus.preset_m[2*SIZE-1:SIZE];
        ld_mu  = (bus.preset_m[SIZE-1:0]      > D9) ? D9 : bus.preset_m[SIZE-1:0];
        ph_t   = bus.preset_h[2*SIZE-1:SIZE];
        ph_u   = bus.preset_h[SIZE-1:0];
        ph_u_c = (ph_u > D9) ? D9 : ph_u;
        h_val  = int'(ph_t) * 10 + int'(ph_u_c);
        if (h_val > HOUR_MAX) begin
            ld_ht = HT;
            ld_hu = HU;
        end else begin
            ld_ht = ph_t;
            ld_hu = ph_u_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= IDLE;
            dir_reg            <= 1'b0;
            {h_t_reg, h_u_reg, m_t_reg, m_u_reg, s_t_reg, s_u_reg} <= '0;
            running_reg        <= 1'b0;
            expired_reg        <= 1'b0;
            expire_pulse_reg   <= 1'b0;
            rollover_pulse_reg <= 1'b0;
        end else begin
            expire_pulse_reg   <= 1'b0;
            rollover_pulse_reg <= 1'b0;
            if (bus.restart) begin
                {h_t_reg, h_u_reg, m_t_reg, m_u_reg, s_t_reg, s_u_reg} <= '0;
                state_reg   <= IDLE;
                running_reg <= 1'b0;
                expired_reg <= 1'b0;
            end else if (bus.load) begin
                {h_t_reg, h_u_reg, m_t_reg, m_u_reg, s_t_reg, s_u_reg} <=
                    {ld_ht, ld_hu, ld_mt, ld_mu, ld_st, ld_su};
                state_reg   <= IDLE;
                running_reg <= 1'b0;
                expired_reg <= 1'b0;
            end else if (bus.stop) begin
                if (state_reg == RUN) begin
                    state_reg   <= PAUSED;
                    running_reg <= 1'b0;
                end
            end else if (bus.start) begin
                if (state_reg == IDLE || state_reg == PAUSED) begin
                    dir_reg <= bus.dir;
                    if (bus.dir && all_zero) begin
                        state_reg        <= EXPIRED;
                        expired_reg      <= 1'b1;
                        expire_pulse_reg <= 1'b1;
                    end else begin
                        state_reg   <= RUN;
                        running_reg <= 1'b1;
                    end
                end
            end else if (bus.pulse && state_reg == RUN) begin
                if (!dir_reg) begin
                    if (!at_max) begin
                        {h_t_reg, h_u_reg, m_t_reg, m_u_reg, s_t_reg, s_u_reg} <=
                            {inc_ht, inc_hu, inc_mt, inc_mu, inc_st, inc_su};
                    end else if (WRAP_UP) begin
                        {h_t_reg, h_u_reg, m_t_reg, m_u_reg, s_t_reg, s_u_reg} <= '0;
                        rollover_pulse_reg <= 1'b1;
                    end else begin
                        state_reg        <= EXPIRED;
                        running_reg      <= 1'b0;
                        expired_reg      <= 1'b1;
                        expire_pulse_reg <= 1'b1;
                    end
                end else begin
                    {h_t_reg, h_u_reg, m_t_reg, m_u_reg, s_t_reg, s_u_reg} <=
                        {dec_ht, dec_hu, dec_mt, dec_mu, dec_st, dec_su};
                    if (is_one) begin
                        state_reg        <= EXPIRED;
                        running_reg      <= 1'b0;
                        expired_reg      <= 1'b1;
                        expire_pulse_reg <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.hours_tens     = h_t_reg;
    assign bus.hours_units    = h_u_reg;
    assign bus.minutes_tens   = m_t_reg;
    assign bus.minutes_units  = m_u_reg;
    assign bus.seconds_tens   = s_t_reg;
    assign bus.seconds_units  = s_u_reg;
    assign bus.running        = running_reg;
    assign bus.expired        = expired_reg;
    assign bus.expire_pulse   = expire_pulse_reg;
    assign bus.rollover_pulse = rollover_pulse_reg;
endmodule

// File: tb/tb_time_counter_hms.sv
// Bench for the HH:MM:SS counter: two instances (wrapping and non-wrapping up-count)
// share one stimulus stream and are compared every cycle against a seconds-based model.
module tb_time_counter_hms;
    localparam int HOUR_MAX = 23;
    localparam int MAXT     = HOUR_MAX * 3600 + 59 * 60 + 59;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pulse = 0, start = 0, stop = 0, restart = 0, load = 0, dir = 0;
    logic [7:0] preset_h = 0, preset_m = 0, preset_s = 0;

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;

    always #5 clk = ~clk;

    time_counter_hms_if #(.SIZE(4)) ifw ();
    time_counter_hms_if #(.SIZE(4)) ifs ();

    assign ifw.pulse = pulse;     assign ifs.pulse = pulse;
    assign ifw.start = start;     assign ifs.start = start;
    assign ifw.stop = stop;       assign ifs.stop = stop;
    assign ifw.restart = restart; assign ifs.restart = restart;
    assign ifw.load = load;       assign ifs.load = load;
    assign ifw.dir = dir;         assign ifs.dir = dir;
    assign ifw.preset_h = preset_h; assign ifs.preset_h = preset_h;
    assign ifw.preset_m = preset_m; assign ifs.preset_m = preset_m;
    assign ifw.preset_s = preset_s; assign ifs.preset_s = preset_s;

    time_counter_hms #(.SIZE(4), .HOUR_MAX(HOUR_MAX), .WRAP_UP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .bus(ifw)
    );
    time_counter_hms #(.SIZE(4), .HOUR_MAX(HOUR_MAX), .WRAP_UP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .bus(ifs)
    );

    // Model: time held as a plain count of seconds
    int tot [2];
    int st  [2];
    bit mdir [2];
    bit mexp [2];
    bit mroll [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            tot[k] = 0; st[k] = M_IDLE; mdir[k] = 0; mexp[k] = 0; mroll[k] = 0;
        end
    end

    function automatic int clamp_preset(logic [7:0] h, logic [7:0] m, logic [7:0] s);
        int ht, hu, mt, mu, stn, su, hv;
        ht = int'(h[7:4]); hu = (h[3:0] > 9) ? 9 : int'(h[3:0]);
        mt = (m[7:4] > 5) ? 5 : int'(m[7:4]); mu = (m[3:0] > 9) ? 9 : int'(m[3:0]);
        stn = (s[7:4] > 5) ? 5 : int'(s[7:4]); su = (s[3:0] > 9) ? 9 : int'(s[3:0]);
        hv = ht * 10 + hu;
        if (hv > HOUR_MAX) hv = HOUR_MAX;
        return hv * 3600 + (mt * 10 + mu) * 60 + stn * 10 + su;
    endfunction

    function automatic logic [23:0] to_bcd(int t);
        int h, m, s;
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic model_step(int k, bit wrap);
        mexp[k] = 0; mroll[k] = 0;
        if (rst) begin
            tot[k] = 0; st[k] = M_IDLE; mdir[k] = 0;
        end else if (restart) begin
            tot[k] = 0; st[k] = M_IDLE;
        end else if (load) begin
            tot[k] = clamp_preset(preset_h, preset_m, preset_s); st[k] = M_IDLE;
        end else if (stop) begin
            if (st[k] == M_RUN) st[k] = M_PAUSE;
        end else if (start) begin
            if (st[k] == M_IDLE || st[k] == M_PAUSE) begin
                mdir[k] = dir;
                if (dir && tot[k] == 0) begin st[k] = M_EXP; mexp[k] = 1; end
                else st[k] = M_RUN;
            end
        end else if (pulse && st[k] == M_RUN) begin
            if (!mdir[k]) begin
                if (tot[k] < MAXT) tot[k] = tot[k] + 1;
                else if (wrap) begin tot[k] = 0; mroll[k] = 1; end
                else begin st[k] = M_EXP; mexp[k] = 1; end
            end else begin
                tot[k] = tot[k] - 1;
                if (tot[k] == 0) begin st[k] = M_EXP; mexp[k] = 1; end
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] dig_w();
        return {ifw.hours_tens, ifw.hours_units, ifw.minutes_tens, ifw.minutes_units,
                ifw.seconds_tens, ifw.seconds_units};
    endfunction
    function automatic logic [23:0] dig_s();
        return {ifs.hours_tens, ifs.hours_units, ifs.minutes_tens, ifs.minutes_units,
                ifs.seconds_tens, ifs.seconds_units};
    endfunction
    // flags packed as {running, expired, expire_pulse, rollover_pulse}
    function automatic logic [3:0] flg_w();
        return {ifw.running, ifw.expired, ifw.expire_pulse, ifw.rollover_pulse};
    endfunction
    function automatic logic [3:0] flg_s();
        return {ifs.running, ifs.expired, ifs.expire_pulse, ifs.rollover_pulse};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_wrap", {dig_w(), flg_w()},
                {to_bcd(tot[0]), st[0] == M_RUN, st[0] == M_EXP, mexp[0], mroll[0]});
            chk("model_stop", {dig_s(), flg_s()},
                {to_bcd(tot[1]), st[1] == M_RUN, st[1] == M_EXP, mexp[1], mroll[1]});
        end
    end

    task automatic drive(string tag, bit p, bit sa, bit so, bit rs, bit ld, bit d);
        @(negedge clk);
        pulse = p; start = sa; stop = so; restart = rs; load = ld; dir = d;
        @(posedge clk);
        #1;
        pulse = 0; start = 0; stop = 0; restart = 0; load = 0;
        if (tag != "")
            $display("txn %-10s wrap=%h/%b nowrap=%h/%b", tag, dig_w(), flg_w(), dig_s(), flg_s());
    endtask

    task automatic do_load(logic [7:0] h, logic [7:0] m, logic [7:0] s);
        preset_h = h; preset_m = m; preset_s = s;
        drive("load", 0, 0, 0, 0, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        $display("txn reset      wrap=%h/%b nowrap=%h/%b", dig_w(), flg_w(), dig_s(), flg_s());
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("reset_digits", dig_w(), 24'h000000);
        chk("reset_flags", flg_w(), 4'b0000);

        // Reset in the middle of a count
        do_load(8'h00, 8'h12, 8'h33);
        drive("start_up", 0, 1, 0, 0, 0, 0);
        drive("pulse", 1, 0, 0, 0, 0, 0);
        chk("mid_count", dig_w(), 24'h001234);
        do_reset();
        chk("rst_mid_digits", dig_w(), 24'h000000);
        chk("rst_mid_flags", flg_w(), 4'b0000);

        // Up-count cascade into hours
        do_load(8'h01, 8'h59, 8'h58);
        drive("start_up", 0, 1, 0, 0, 0, 0);
        drive("pulse", 1, 0, 0, 0, 0, 0);
        chk("up_015959", dig_w(), 24'h015959);
        drive("pulse", 1, 0, 0, 0, 0, 0);
        chk("up_020000", dig_w(), 24'h020000);
        drive("pulse", 1, 0, 0, 0, 0, 0);
        chk("up_020001", dig_w(), 24'h020001);
        chk("up_running", flg_w(), 4'b1000);

        // Top of range: wrap vs. expire
        do_load(8'h23, 8'h59, 8'h59);
        drive("start_up", 0, 1, 0, 0, 0, 0);
        drive("pulse", 1, 0, 0, 0, 0, 0);
        chk("wrap_digits", dig_w(), 24'h000000);
        chk("wrap_flags", flg_w(), 4'b1001);
        chk("nowrap_digits", dig_s(), 24'h235959);
        chk("nowrap_flags", flg_s(), 4'b0110);
        drive("idle", 0, 0, 0, 0, 0, 0);
        chk("wrap_flags_after", flg_w(), 4'b1000);
        chk("nowrap_flags_after", flg_s(), 4'b0100);

        // Countdown through a minute borrow to expiry
        do_load(8'h00, 8'h01, 8'h00);
        drive("start_dn", 0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 60; i++) begin
            drive((i == 0 || i == 59) ? "pulse" : "", 1, 0, 0, 0, 0, 0);
            if (i == 0) chk("dn_000059", dig_w(), 24'h000059);
        end
        chk("dn_zero", dig_w(), 24'h000000);
        chk("dn_expire", flg_w(), 4'b0110);
        drive("pulse", 1, 0, 0, 0, 0, 0);
        chk("dn_hold", {dig_w(), flg_w()}, {24'h000000, 4'b0100});

        // Preset clamping, then down-start from zero
        do_load(8'h47, 8'h7A, 8'h6F);
        chk("clamp_w", dig_w(), 24'h235959);
        chk("clamp_s", dig_s(), 24'h235959);
        drive("restart", 0, 0, 0, 1, 0, 0);
        drive("start_dn0", 0, 1, 0, 0, 0, 1);
        chk("zero_start_dn", flg_w(), 4'b0110);

        // Pause priority and resume
        do_load(8'h00, 8'h00, 8'h10);
        drive("start_up", 0, 1, 0, 0, 0, 0);
        drive("stop_pulse", 1, 0, 1, 0, 0, 0);
        chk("pause_digits", dig_w(), 24'h000010);
        chk("pause_flags", flg_w(), 4'b0000);
        drive("pulse", 1, 0, 0, 0, 0, 0);
        chk("paused_hold", dig_w(), 24'h000010);
        drive("resume", 0, 1, 0, 0, 0, 0);
        drive("pulse", 1, 0, 0, 0, 0, 0);
        chk("resume_count", {dig_w(), flg_w()}, {24'h000011, 4'b1000});
        drive("restart", 0, 0, 0, 1, 0, 0);
        chk("restart_run", {dig_w(), flg_w()}, {24'h000000, 4'b0000});

        // Randomised control mix, checked each cycle by the model comparison
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            pulse   = ($urandom_range(0, 1) == 0);
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 15) == 0);
            restart = ($urandom_range(0, 63) == 0);
            load    = ($urandom_range(0, 31) == 0);
            dir     = ($urandom_range(0, 1) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 1) == 0) begin
                preset_h = 8'($urandom_range(0, 255));
                preset_m = 8'($urandom_range(0, 255));
                preset_s = 8'($urandom_range(0, 255));
            end else begin
                preset_h = ($urandom_range(0, 1) == 0) ? 8'h23 : 8'h00;
                preset_m = ($urandom_range(0, 1) == 0) ? 8'h59 : 8'h00;
                preset_s = 8'($urandom_range(0, 1) == 0 ? 8'h58 : 8'h02);
            end
        end
        @(negedge clk);
        pulse = 0; start = 0; stop = 0; restart = 0; load = 0; rst = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/time_counter_hms.md
Name: time_counter_hms

Overview:
- Parametrised successor to the team's MM:SS BCD time counter.
- Adds an hours field, up/down direction, preset load, start/stop control and expiry/rollover signalling.
- Sits between the 1 Hz pulse generator and the 7-segment display driver.
- Used as a stopwatch (count up) or a kitchen/countdown timer (count down).

Parameters:
- SIZE, 4, width of each BCD digit output.
- HOUR_MAX, 23, maximum hours value (decimal, 1..99); the upper count bound is HOUR_MAX:59:59.
- WRAP_UP, 1, 1 = up-count wraps from HOUR_MAX:59:59 to 00:00:00; 0 = up-count stops there and expires.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pulse  in  1  one-cycle count enable (1 Hz tick)
- start  in  1  one-cycle request to begin/resume counting
- stop  in  1  one-cycle request to pause
- restart  in  1  clear all digits to 0, go IDLE
- load  in  1  load preset digits, go IDLE
- dir  in  1  0 = up, 1 = down; latched on accepted start
- preset_h  in  2*SIZE  BCD hours {tens, units}
- preset_m  in  2*SIZE  BCD minutes {tens, units}
- preset_s  in  2*SIZE  BCD seconds {tens, units}
- hours_tens, hours_units, minutes_tens, minutes_units, seconds_tens, seconds_units  out  SIZE each  current BCD digits
- running  out  1  high in RUN
- expired  out  1  level, high in EXPIRED
- expire_pulse  out  1  one cycle on entry to EXPIRED
- rollover_pulse  out  1  one cycle on up-wrap to 00:00:00

Behaviour:
- All outputs are registered. Updates on the clk edge are visible the next cycle.
- Reset (rst=1 at a clk edge): all digits 0, state IDLE, running/expired/expire_pulse/rollover_pulse 0, latched dir 0. Reset overrides everything, including mid-count.
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
- Control priority, highest first: rst > restart > load > stop > start > pulse.
- restart: digits := 0, state IDLE, from any state.
- load: clamp the preset, then load it; state IDLE, from any state including RUN.
  - Seconds/minutes tens > 5 clamp to 5; units > 9 clamp to 9.
  - Hours: a units digit > 9 clamps to 9. If the resulting value > HOUR_MAX, hours := HOUR_MAX.
- start:
  - IDLE/PAUSED -> RUN and latch dir.
  - Down-count with digits all 0: go directly to EXPIRED (expire_pulse=1) instead of RUN.
  - In RUN: ignored. In EXPIRED: ignored; restart or load is required.
- stop: RUN -> PAUSED. Ignored in other states.
- pulse is honoured only in RUN and only when no higher-priority input is active that cycle; elsewhere it is ignored.
- Up-count: standard BCD cascade. Seconds units 9->0 carries into seconds tens 5->0, then minutes, then hours.
  - At HOUR_MAX:59:59 with WRAP_UP=1: digits -> 00:00:00, rollover_pulse=1, stay in RUN.
  - At HOUR_MAX:59:59 with WRAP_UP=0: digits hold, -> EXPIRED, expire_pulse=1.
- Down-count: BCD borrow cascade. Units 0->9 borrows from tens; seconds tens 0->5 borrows from minutes; minutes borrows from hours.
  - When the decrement produces 00:00:00: digits = 0, -> EXPIRED, expire_pulse=1 in the same update.
- Hours arithmetic is on the two-digit BCD value. Units 9->0 increments tens; units 0->9 on borrow decrements tens.
- expire_pulse and rollover_pulse are high for exactly one cycle and are never high simultaneously.
- In EXPIRED, digits are frozen and expired=1.
- dir changes while in RUN have no effect until the next accepted start.
- Simultaneous inputs:
  - stop+pulse in RUN: pause wins, no increment.
  - start+pulse in IDLE: transition only, no count that cycle.

Test Plan:
- rst=1 for 2 cycles mid-count at 00:12:34 -> all digits 0, state IDLE, all flags 0 on the next cycle.
- load 01:59:58, start with dir=0, 3 pulses -> 01:59:59, 02:00:00, 02:00:01; running=1 throughout.
- HOUR_MAX=23, WRAP_UP=1: load 23:59:59, start up, 1 pulse -> 00:00:00, rollover_pulse=1 for one cycle, running stays 1. Repeat with WRAP_UP=0 -> digits hold 23:59:59, expired=1, expire_pulse one cycle.
- load 00:01:00, start with dir=1, 60 pulses -> passes 00:00:59, ends at 00:00:00 with expire_pulse=1 on the 60th update; further pulses leave 00:00:00 and no new expire_pulse.
- Clamping: load preset_h=8'h47, preset_m=8'h7A, preset_s=8'h6F with HOUR_MAX=23 -> digits 23:59:59.
  - Start with dir=1 at 00:00:00 -> immediate EXPIRED, expire_pulse=1.
- Pause/priority: RUN at 00:00:10, stop+pulse same cycle -> PAUSED at 00:00:10; pulses ignored; start -> RUN, next pulse -> 00:00:11. restart asserted in RUN -> 00:00:00, IDLE.
